// File: rtl/fetch_seq.sv
// Y86 byte-serial fetch: header, register and constant bytes are read one per imem_ack. Result in N+1 cycles after accept
// (N bytes, zero-wait memory). Memory stalls hold imem_req/imem_addr; the result is held in DONE until out_ready.
module fetch_seq #(
  parameter int DATA_WID = 64
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [DATA_WID-1:0] pc_in,
  input  logic                pc_valid,
  output logic                pc_ready,
  output logic                imem_req,
  output logic [DATA_WID-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [7:0]          imem_rdata,
  input  logic                imem_err,
  output logic [3:0]          icode,
  output logic [3:0]          ifun,
  output logic [3:0]          rA,
  output logic [3:0]          rB,
  output logic [DATA_WID-1:0] valC,
  output logic [DATA_WID-1:0] valP,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                instr_valid,
  output logic                instr_error,
  output logic                imem_error
);

  typedef enum logic [2:0] {IDLE, HDR, REG, CONST, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_WID-1:0] pc_q, pc_d, addr_q, addr_d, valc_q, valc_d, valp_q, valp_d;
  logic [3:0]          icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                req_q, req_d, ov_q, ov_d, ierr_q, ierr_d, merr_q, merr_d;
  logic [3:0]          len;
  logic                hdr_reg, hdr_const, take;

  assign take = req_q & imem_ack;

  // Instruction length and follow-on phases decoded straight from the header byte.
  always_comb begin
    len       = 4'd1;
    hdr_reg   = 1'b0;
    hdr_const = 1'b0;
    case (imem_rdata[7:4])
      4'h2, 4'h6, 4'hA, 4'hB: begin len = 4'd2;  hdr_reg = 1'b1; end
      4'h7, 4'h8:             begin len = 4'd9;  hdr_const = 1'b1; end
      4'h3, 4'h4, 4'h5:       begin len = 4'd10; hdr_reg = 1'b1; end
      default:                len = 4'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ov_d    = ov_q;
    ierr_d  = ierr_q;
    merr_d  = merr_q;
    case (state_q)
      IDLE: begin
        if (pc_valid) begin
          state_d = HDR;
          pc_d    = pc_in;
          addr_d  = pc_in;
          req_d   = 1'b1;
          icode_d = 4'h0;
          ifun_d  = 4'h0;
          ra_d    = 4'hF;
          rb_d    = 4'hF;
          valc_d  = '0;
          valp_d  = '0;
          cnt_d   = 3'd0;
          ierr_d  = 1'b0;
          merr_d  = 1'b0;
        end
      end
      HDR: begin
        if (take) begin
          addr_d  = addr_q + 1'b1;
          icode_d = imem_rdata[7:4];
          ifun_d  = imem_rdata[3:0];
          valp_d  = pc_q + DATA_WID'(len);
          ierr_d  = (imem_rdata[7:4] > 4'hB);
          if (hdr_reg) begin
            state_d = REG;
          end else if (hdr_const) begin
            state_d = CONST;
          end else begin
            state_d = DONE;
            req_d   = 1'b0;
            ov_d    = 1'b1;
          end
        end
      end
      REG: begin
        if (take) begin
          addr_d = addr_q + 1'b1;
          ra_d   = imem_rdata[7:4];
          rb_d   = imem_rdata[3:0];
          if (icode_q inside {4'h3, 4'h4, 4'h5}) begin
            state_d = CONST;
          end else begin
            state_d = DONE;
            req_d   = 1'b0;
            ov_d    = 1'b1;
          end
        end
      end
      CONST: begin
        if (take) begin
          addr_d = addr_q + 1'b1;
          valc_d[8*cnt_q +: 8] = imem_rdata;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = DONE;
            req_d   = 1'b0;
            ov_d    = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          ov_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A faulting byte wins over any decode from the same cycle; fields fetched so far are kept.
    if (take && imem_err) begin
      state_d = DONE;
      req_d   = 1'b0;
      ov_d    = 1'b1;
      merr_d  = 1'b1;
      ierr_d  = 1'b0;
      valp_d  = pc_q;
      addr_d  = addr_q;
      icode_d = icode_q;
      ifun_d  = ifun_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      valc_d  = valc_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      valc_q  <= '0;
      valp_q  <= '0;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      ov_q    <= 1'b0;
      ierr_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ov_q    <= ov_d;
      ierr_q  <= ierr_d;
      merr_q  <= merr_d;
    end
  end

  assign pc_ready    = (state_q == IDLE);
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign icode       = icode_q;
  assign ifun        = ifun_q;
  assign rA          = ra_q;
  assign rB          = rb_q;
  assign valC        = valc_q;
  assign valP        = valp_q;
  assign out_valid   = ov_q;
  assign instr_error = ierr_q;
  assign imem_error  = merr_q;
  assign instr_valid = ov_q & ~ierr_q & ~merr_q;

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter DATA_WID, default 64, width of PC, address and valC/valP.
REQ-002 CLK  in  1  sole clock, rising edge.
REQ-003 RSTn  in  1  reset, asynchronous, active-low.
REQ-004 pc_in  in  DATA_WID  address of the instruction to fetch.
REQ-005 pc_valid  in  1  pc_in valid; accepted when pc_valid & pc_ready.
REQ-006 pc_ready  out  1  high only in IDLE.
REQ-007 imem_req  out  1  byte read request.
REQ-008 imem_addr  out  DATA_WID  byte address of current request.
REQ-009 imem_ack  in  1  byte returned this cycle; imem_rdata/imem_err qualified by it.
REQ-010 imem_rdata  in  8  returned byte.
REQ-011 imem_err  in  1  access fault for current byte.
REQ-012 icode, ifun, rA, rB  out  4 each  decoded Y86 fields.
REQ-013 valC  out  DATA_WID  little-endian constant; valP  out  DATA_WID  next sequential PC.
REQ-014 out_valid  out  1  result valid; out_ready  in  1  consumer (PC update stage) accepts.
REQ-015 instr_valid, instr_error, imem_error  out  1 each  result status.

Function
REQ-016 FSM states: IDLE, HDR, REG, CONST, DONE; IDLE -> HDR on pc_valid & pc_ready, pc_in latched.
REQ-017 Length by icode: 0,1,9 -> 1 byte; 2,6,A,B -> 2; 7,8 -> 9 (HDR+CONST); 3,4,5 -> 10 (HDR+REG+CONST); icode > B -> 1 byte, instr_error=1.
REQ-018 HDR: byte 0 -> icode=rdata[7:4], ifun=rdata[3:0]; next state REG, CONST or DONE per REQ-017.
REQ-019 REG: byte 1 -> rA=rdata[7:4], rB=rdata[3:0]; next CONST (icode 3,4,5) or DONE.
REQ-020 CONST: 8 bytes via 3-bit counter, byte k -> valC[8k+7:8k]; DONE after k=7.
REQ-021 imem_addr = latched PC + byte index, mod 2^DATA_WID (wraps).
REQ-022 imem_req high in HDR/REG/CONST; imem_req and imem_addr held stable until imem_ack; one byte consumed per ack.
REQ-023 Zero-wait latency: accept in cycle T, first req in T+1, out_valid in T+1+N for an N-byte instruction.
REQ-024 valP = latched PC + length, mod 2^DATA_WID; fields not fetched (rA/rB, valC) output 0xF/0xF and 0 respectively.
REQ-025 imem_ack & imem_err: abort immediately, no further req, DONE with imem_error=1, instr_valid=0, valP = latched PC.
REQ-026 instr_valid = out_valid & ~instr_error & ~imem_error.
REQ-027 DONE: out_valid=1, all outputs held stable while out_ready=0; DONE -> IDLE on out_ready.
REQ-028 pc_valid ignored outside IDLE; no pc_in/pc_valid path into result combinationally.
REQ-029 imem_ack while imem_req=0 ignored.

Reset
REQ-030 RSTn low: immediately state=IDLE, imem_req=0, out_valid=0, pc_ready=1 after release, all data/status outputs 0, imem_addr 0.
REQ-031 Reset mid-fetch aborts without producing a result; first fetch after release behaves per REQ-016..027.

Verification
REQ-032 nop: pc_in=0x100, mem[0x100]=0x10, ack same cycle -> one req at 0x100, icode=1, ifun=0, valP=0x101, out_valid at T+2.
REQ-033 irmovq at 0x200, bytes 30 F0 EF CD AB 89 67 45 23 01 -> rA=F, rB=0, valC=0x0123456789ABCDEF, valP=0x20A, out_valid at T+11.
REQ-034 jXX (0x73 + 8 bytes) with ack every 3rd cycle -> addr stable between acks, valC correct, valP=pc+9; out_ready=0 for 5 cycles holds all outputs.
REQ-035 byte 0xE0 -> instr_error=1, instr_valid=0, valP=pc+1; imem_err on byte 3 of rmmovq -> imem_error=1, no further req.
REQ-036 call at pc=0xFFFFFFFFFFFFFFFE -> addresses wrap ...FE, ...FF, 0x0..0x6, valP=0x7.
REQ-037 RSTn low during CONST byte 4 -> imem_req drops same instant, out_valid never asserted, next fetch correct.
